// File: rtl/cbl_dmem_responder.sv
// cbl_dmem_responder: memory end of the CBL core's load/store port.
// Accepts one word request at a time, performs the access after LATENCY
// cycles and holds the result on a valid/ready response channel.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer holds valid and its payload
// stable until that edge, and ready never depends on valid.
//
// The FSM state is kept in the plainly named signal `state` (IDLE/BUSY/RESP)
// so that checkers can bind to it directly.
module cbl_dmem_responder #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_MEM   = 5,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [REG_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int         IDX_W    = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // The 4-bit down-counter only covers latencies of 1..15.
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("cbl_dmem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Storage is deliberately not reset; benches preload it as data[i].
    logic [REG_WIDTH-1:0] data [NUM_MEM];

    logic [3:0]           cnt;
    logic                 lat_we;
    logic [REG_WIDTH-1:0] lat_addr;
    logic [REG_WIDTH-1:0] lat_wdata;

    logic                 req_fire;
    logic                 rsp_fire;
    logic                 commit;
    logic                 in_range;
    logic [IDX_W-1:0]     lat_idx;

    // Ready only while idle and out of reset; independent of req_valid.
    assign req_ready = (state == IDLE) && rst;

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign commit   = (state == BUSY) && (cnt == 4'd0);

    // Full-width unsigned compare so high address bits never alias onto
    // a valid word; the index is only used when in_range is true.
    assign in_range = (lat_addr < REG_WIDTH'(NUM_MEM));
    assign lat_idx  = lat_addr[IDX_W-1:0];

    // Next-state decode: one outstanding request, response held until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = BUSY;
            BUSY:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latency counter: loaded on acceptance, counts down while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (req_fire) begin
            cnt <= CNT_LOAD;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture the request so later changes on the inputs have no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (req_fire) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Response registers: filled at the commit edge, cleared when consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (!lat_we && in_range) ? data[lat_idx] : '0;
            rsp_err   <= !in_range;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Store commit: the write lands only at the commit edge, never under reset.
    always_ff @(posedge clk) begin
        if (rst && commit && lat_we && in_range) begin
            data[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_cbl_dmem_responder.sv
// Bench for cbl_dmem_responder: four instances at LATENCY 1, 2, 3 and 15,
// driven one at a time and checked against a word-array model of memory.
module tb_cbl_dmem_responder;

    localparam int NI = 4;
    localparam int LATS [NI] = '{1, 2, 3, 15};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic [31:0] mem_view  [NI][5];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        cbl_dmem_responder #(
            .REG_WIDTH(32),
            .NUM_MEM  (5),
            .LATENCY  (LATS[k])
        ) u_dut (
            .clk      (clk),
            .rst      (rst[k]),
            .req_valid(req_valid[k]),
            .req_ready(req_ready[k]),
            .req_we   (req_we[k]),
            .req_addr (req_addr[k]),
            .req_wdata(req_wdata[k]),
            .rsp_valid(rsp_valid[k]),
            .rsp_ready(rsp_ready[k]),
            .rsp_rdata(rsp_rdata[k]),
            .rsp_err  (rsp_err[k])
        );
        // Preload data[i] = i+1 and expose the array for observation.
        initial begin
            for (int i = 0; i < 5; i++) u_dut.data[i] = 32'(i + 1);
        end
        for (genvar i = 0; i < 5; i++) begin : g_view
            assign mem_view[k][i] = u_dut.data[i];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mem_m [NI][5];

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem(input int k);
        for (int i = 0; i < 5; i++) check("mem_contents", mem_view[k][i], mem_m[k][i]);
    endtask

    // ---------------- driver tasks ----------------
    // One full transaction. Called between edges with the instance idle.
    // delay = cycles of rsp_ready=0 after the response appears.
    task automatic do_txn(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, output int acc);
        int          lat;
        bit          in_rng;
        int          idx;
        logic [31:0] old;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          waited;
        lat    = LATS[k];
        in_rng = (addr < 32'd5);
        idx    = in_rng ? int'(addr) : 0;
        old    = mem_m[k][idx];
        exp_rd = (!we && in_rng) ? old : 32'd0;
        exp_er = !in_rng;

        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        rsp_ready[k] = (delay == 0);
        waited = 0;
        while (req_ready[k] !== 1'b1 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready[k] !== 1'b1) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            acc = cycle;
            return;
        end
        @(posedge clk); #1;
        acc = cycle;

        // Inputs after acceptance are noise that must be ignored.
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;

        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            check("rsp_valid_latency", 32'(rsp_valid[k]), 32'(c == lat));
            check("req_ready_busy", 32'(req_ready[k]), 32'd0);
            if (we && in_rng)
                check("store_visibility", mem_view[k][idx], (c == lat) ? wdata : old);
        end
        if (we && in_rng) mem_m[k][idx] = wdata;
        check("rsp_rdata", rsp_rdata[k], exp_rd);
        check("rsp_err", 32'(rsp_err[k]), 32'(exp_er));

        for (int d = 1; d <= delay; d++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid[k]), 32'd1);
            check("hold_rdata", rsp_rdata[k], exp_rd);
            check("hold_err", 32'(rsp_err[k]), 32'(exp_er));
            check("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        check("rsp_cleared_valid", 32'(rsp_valid[k]), 32'd0);
        check("rsp_cleared_rdata", rsp_rdata[k], 32'd0);
        check("rsp_cleared_err", 32'(rsp_err[k]), 32'd0);
        check("req_ready_return", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'($urandom_range(0, 1));
        check_mem(k);
    endtask

    // Back-to-back loads with rsp_ready=1: accepts are LAT+2 edges apart,
    // i.e. LAT+1 non-ready cycles between consecutive accepts.
    task automatic run_burst(input int k, input int n);
        int acc;
        int prev;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            do_txn(k, 1'b0, 32'($urandom_range(0, 4)), 32'd0, 0, acc);
            if (i > 0) check("accept_spacing", 32'(acc - prev), 32'(LATS[k] + 2));
            prev = acc;
        end
    endtask

    task automatic run_random(input int k, input int n);
        int          acc;
        int          r;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = 32'(r);
            else if (r == 7) addr = $urandom;
            else             addr = 32'($urandom_range(0, 4)) | (32'd1 << $urandom_range(3, 31));
            do_txn(k, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3), acc);
        end
    endtask

    // Reset while BUSY aborts the store; reset while in RESP drops the response.
    task automatic reset_cases(input int k);
        int acc;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b1;
        req_addr[k]  = 32'd4;
        req_wdata[k] = 32'd9;
        rsp_ready[k] = 1'b1;
        check("pre_reset_ready", 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        check("accepted_ready_low", 32'(req_ready[k]), 32'd0);
        rst[k]       = 1'b0;
        req_valid[k] = 1'b0;
        #1;
        check("ready_low_in_reset", 32'(req_ready[k]), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_busy_no_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_busy_data4", mem_view[k][4], mem_m[k][4]);
        end
        rst[k] = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready[k]), 32'd1);
        repeat (LATS[k] + 2) begin
            @(posedge clk); #1;
            check("no_late_valid", 32'(rsp_valid[k]), 32'd0);
            check("no_late_store", mem_view[k][4], mem_m[k][4]);
        end
        do_txn(k, 1'b0, 32'd4, 32'd0, 0, acc);

        // Pending response discarded by reset.
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = 32'd0;
        rsp_ready[k] = 1'b0;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        repeat (LATS[k]) @(posedge clk);
        #1;
        check("resp_pending_valid", 32'(rsp_valid[k]), 32'd1);
        check("resp_pending_rdata", rsp_rdata[k], mem_m[k][0]);
        rst[k] = 1'b0;
        @(posedge clk); #1;
        rst[k] = 1'b1;
        #1;
        check("rst_resp_valid", 32'(rsp_valid[k]), 32'd0);
        check("rst_resp_rdata", rsp_rdata[k], 32'd0);
        check("rst_resp_ready", 32'(req_ready[k]), 32'd1);
        do_txn(k, 1'b0, 32'd3, 32'd0, 0, acc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int acc2;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 5; i++) mem_m[k][i] = 32'(i + 1);
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            check("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
            rst[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < NI; k++) check("reset_req_ready", 32'(req_ready[k]), 32'd1);

        // LATENCY=2 directed cases.
        do_txn(1, 1'b0, 32'd1, 32'd0, 0, acc);
        do_txn(1, 1'b1, 32'd2, 32'd3, 0, acc);
        do_txn(1, 1'b0, 32'd2, 32'd0, 0, acc);
        do_txn(1, 1'b0, 32'd0, 32'd0, 5, acc);
        do_txn(1, 1'b0, 32'd1, 32'd0, 0, acc2);
        check("backpressure_spacing", 32'(acc2 - acc), 32'(LATS[1] + 2 + 5));
        do_txn(1, 1'b0, 32'd5, 32'd0, 0, acc);
        do_txn(1, 1'b1, 32'hFFFF_FFFF, 32'd7, 0, acc);
        do_txn(1, 1'b1, 32'h0000_0100, 32'd7, 0, acc);
        do_txn(1, 1'b0, 32'h8000_0002, 32'd0, 2, acc);

        // LATENCY=3 reset behaviour.
        reset_cases(2);

        // Latency sweep extremes.
        run_burst(0, 6);
        run_burst(3, 4);

        // Randomized traffic.
        run_random(0, 40);
        run_random(1, 40);
        run_random(2, 30);
        run_random(3, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
